// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants: XLEN default, control-flag indices, rs/rt field positions
package pipe_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int FLAG_COUNT   = 4;

    typedef enum int {
        FLAG_BRANCH = 0,
        FLAG_JUMP   = 1,
        FLAG_BEQ    = 2,
        FLAG_BNE    = 3
    } flag_idx_e;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

endpackage

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID decoupling queue; optional same-cycle bypass via IF_ID_QUEUE_BYPASS_EN
module if_id_queue
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4,
    parameter int FLAGW = FLAG_COUNT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    input  logic [FLAGW-1:0]         in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [FLAGW-1:0]         out_flags,
    output logic [4:0]               out_rs,
    output logic [4:0]               out_rt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [XLEN-1:0]  mem_inst  [DEPTH];
    logic [FLAGW-1:0] mem_flags [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign in_ready = !reset || (count_q < DEPTH_C);

`ifdef IF_ID_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid;
`else
    assign bypass = 1'b0;
`endif

    // Gating with reset keeps decode from seeing a handshake while the queue is being cleared.
    assign out_valid = reset && !flush && (!empty || bypass);

    assign push  = in_valid && in_ready;
    assign pop   = out_valid && out_ready;
    assign wr_en = push && !(bypass && out_ready);
    assign rd_en = pop && !empty;

    always_comb begin
        out_pc    = '0;
        out_inst  = '0;
        out_flags = '0;
        if (out_valid) begin
`ifdef IF_ID_QUEUE_BYPASS_EN
            if (bypass) begin
                out_pc    = in_pc;
                out_inst  = in_inst;
                out_flags = in_flags;
            end else begin
                out_pc    = mem_pc[rd_ptr];
                out_inst  = mem_inst[rd_ptr];
                out_flags = mem_flags[rd_ptr];
            end
`else
            out_pc    = mem_pc[rd_ptr];
            out_inst  = mem_inst[rd_ptr];
            out_flags = mem_flags[rd_ptr];
`endif
        end
    end

    assign out_rs = out_inst[RS_MSB:RS_LSB];
    assign out_rt = out_inst[RT_MSB:RT_LSB];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible through out_valid.
    always_ff @(posedge clk) begin
        if (reset && !flush && wr_en) begin
            mem_pc[wr_ptr]    <= in_pc;
            mem_inst[wr_ptr]  <= in_inst;
            mem_flags[wr_ptr] <= in_flags;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - table-driven bench for if_id_queue plus stream and bypass/latency sequences
module tb_if_id_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int FLAGW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_inst;
    logic [FLAGW-1:0]  in_flags;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_inst;
    logic [FLAGW-1:0]  out_flags;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [2:0]        count;

    always #5 clk = ~clk;

    if_id_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .FLAGW(FLAGW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_flags  (in_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_flags (out_flags),
        .out_rs    (out_rs),
        .out_rt    (out_rt),
        .count     (count)
    );

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [3:0]  flags;
        logic        exp_valid;
        logic        exp_ready;
        logic [2:0]  exp_count;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [3:0]  exp_flags;
        logic [4:0]  exp_rs;
        logic [4:0]  exp_rt;
    } vec_t;

    logic [31:0] e_pc    [5] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
    logic [31:0] e_inst  [5] = '{32'h00220000, 32'h00640000, 32'h00A60000, 32'h00E80000, 32'h014B4820};
    logic [3:0]  e_flags [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011};
    logic [4:0]  e_rs    [5] = '{5'd1, 5'd3, 5'd5, 5'd7, 5'd10};
    logic [4:0]  e_rt    [5] = '{5'd2, 5'd4, 5'd6, 5'd8, 5'd11};

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic iv, logic ordy, int in_e,
                                logic ev, logic er, int ec, int head);
        vec_t v;
        v.rst_n     = r;
        v.flush     = f;
        v.in_valid  = iv;
        v.out_ready = ordy;
        v.pc        = (in_e < 0) ? 32'h0 : e_pc[in_e];
        v.inst      = (in_e < 0) ? 32'h0 : e_inst[in_e];
        v.flags     = (in_e < 0) ? 4'h0  : e_flags[in_e];
        v.exp_valid = ev;
        v.exp_ready = er;
        v.exp_count = 3'(ec);
        v.exp_pc    = (head < 0) ? 32'h0 : e_pc[head];
        v.exp_inst  = (head < 0) ? 32'h0 : e_inst[head];
        v.exp_flags = (head < 0) ? 4'h0  : e_flags[head];
        v.exp_rs    = (head < 0) ? 5'd0  : e_rs[head];
        v.exp_rt    = (head < 0) ? 5'd0  : e_rt[head];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got;
        logic [31:0] sb[$];

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst = '0; in_flags = '0;
        repeat (2) @(posedge clk);
        #1;

        tbl.push_back(mk(0,0,0,0,-1, 0,1,0,-1));  // reset state
        tbl.push_back(mk(1,0,1,0, 0, 0,1,0,-1));  // fill
        tbl.push_back(mk(1,0,1,0, 1, 1,1,1, 0));
        tbl.push_back(mk(1,0,1,0, 2, 1,1,2, 0));
        tbl.push_back(mk(1,0,1,0, 3, 1,1,3, 0));
        tbl.push_back(mk(1,0,1,0, 4, 1,0,4, 0));  // full, 5th offer refused
        tbl.push_back(mk(1,0,1,1, 4, 1,0,4, 0));  // full with out_ready: pop, no push
        tbl.push_back(mk(1,0,0,1,-1, 1,1,3, 1));  // drain
        tbl.push_back(mk(1,0,0,1,-1, 1,1,2, 2));
        tbl.push_back(mk(1,0,0,1,-1, 1,1,1, 3));
        tbl.push_back(mk(1,0,0,1,-1, 0,1,0,-1));  // empty: bubble
        tbl.push_back(mk(1,0,1,0, 4, 0,1,0,-1));  // one-cycle latency
        tbl.push_back(mk(1,0,0,0,-1, 1,1,1, 4));  // field extraction rs=10 rt=11
        tbl.push_back(mk(1,0,1,1, 0, 1,1,1, 4));  // push+pop same cycle
        tbl.push_back(mk(1,0,0,0,-1, 1,1,1, 0));
        tbl.push_back(mk(1,0,1,0, 1, 1,1,1, 0));
        tbl.push_back(mk(1,0,1,0, 2, 1,1,2, 0));
        tbl.push_back(mk(1,1,1,1, 3, 0,1,3,-1));  // flush at count 3 with push
        tbl.push_back(mk(1,0,0,0,-1, 0,1,0,-1));  // flushed, push lost
        tbl.push_back(mk(1,0,1,0, 0, 0,1,0,-1));
        tbl.push_back(mk(1,0,1,0, 1, 1,1,1, 0));
        tbl.push_back(mk(0,0,0,1,-1, 0,1,2,-1));  // reset mid-stream at count 2
        tbl.push_back(mk(1,0,0,0,-1, 0,1,0,-1));  // cleared

        for (int i = 0; i < tbl.size(); i++) begin
            reset     = tbl[i].rst_n;
            flush     = tbl[i].flush;
            in_valid  = tbl[i].in_valid;
            out_ready = tbl[i].out_ready;
            in_pc     = tbl[i].pc;
            in_inst   = tbl[i].inst;
            in_flags  = tbl[i].flags;
            #4;
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("row%0d in_ready",  i), 32'(in_ready),  32'(tbl[i].exp_ready));
            chk($sformatf("row%0d count",     i), 32'(count),     32'(tbl[i].exp_count));
            chk($sformatf("row%0d out_pc",    i), out_pc,         tbl[i].exp_pc);
            chk($sformatf("row%0d out_inst",  i), out_inst,       tbl[i].exp_inst);
            chk($sformatf("row%0d out_flags", i), 32'(out_flags), 32'(tbl[i].exp_flags));
            chk($sformatf("row%0d out_rs",    i), 32'(out_rs),    32'(tbl[i].exp_rs));
            chk($sformatf("row%0d out_rt",    i), 32'(out_rt),    32'(tbl[i].exp_rt));
            next_cycle();
        end

        // Continuous stream with decode always ready: order must hold through pointer wrap.
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (sent < 8);
            in_pc    = 32'h100 + 32'(4 * sent);
            in_inst  = 32'h0;
            in_flags = 4'h0;
            #4;
            if (in_valid && in_ready) begin
                sb.push_back(in_pc);
                sent++;
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("stream unexpected out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk($sformatf("stream out_pc %0d", got), out_pc, sb.pop_front());
                    got++;
                end
            end
            next_cycle();
            if (sent == 8 && sb.size() == 0) break;
        end
        in_valid = 1'b0;
        chk("stream entries delivered", 32'(got), 32'd8);

        // Empty queue offered an entry with decode ready.
        in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h0; in_flags = 4'h0; out_ready = 1'b1;
        #4;
`ifdef IF_ID_QUEUE_BYPASS_EN
        chk("bypass out_valid", 32'(out_valid), 32'd1);
        chk("bypass out_pc",    out_pc,         32'h40);
        next_cycle();
        in_valid = 1'b0;
        #4;
        chk("bypass count stays 0", 32'(count), 32'd0);
        chk("bypass no residue",    32'(out_valid), 32'd0);
        next_cycle();
`else
        chk("latency out_valid same cycle", 32'(out_valid), 32'd0);
        chk("latency out_pc same cycle",    out_pc,         32'h0);
        next_cycle();
        in_valid = 1'b0;
        #4;
        chk("latency out_valid next cycle", 32'(out_valid), 32'd1);
        chk("latency out_pc next cycle",    out_pc,         32'h40);
        next_cycle();
        #4;
        chk("latency drained count", 32'(count), 32'd0);
        next_cycle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
